// File: rtl/parity_tx_ctrl.sv
// Serial frame transmitter: start bit, 8 data bits LSB-first, parity bit, stop bit.
// One byte accepted per valid/ready handshake while idle; parity is fixed at capture.
module parity_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;

    // Counter only advances inside a frame and clears on every bit boundary.
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (data_valid) begin
          shift_d = data_in;
          par_d   = (^data_in) ^ (PARITY_ODD != 0);
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            // Next bit is driven from shift_q[1] as the register shifts this edge.
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign data_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == STOP) && bit_end;
  assign tx_out     = tx_q;

endmodule

// File: tb/tb_parity_tx_ctrl.sv
// Scoreboard bench for parity_tx_ctrl: three instances (4 clk/bit even, 4 clk/bit odd,
// 1 clk/bit even); stimulus pushes hand-computed frames, a negedge monitor checks them.
module tb_parity_tx_ctrl;

  localparam int N = 3;

  typedef struct {
    int         id;
    logic [7:0] b;
    logic       p;
    int         gap;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic [N-1:0][7:0]   din;
  logic [N-1:0]        dv, dr, tx, bsy, dn;

  exp_t sb[$];
  int   checks, failures;
  logic end_req, end_done;

  for (genvar g = 0; g < N; g++) begin : g_dut
    parity_tx_ctrl #(
      .CLKS_PER_BIT((g == 2) ? 1 : 4),
      .PARITY_ODD  ((g == 1) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (din[g]),
      .data_valid(dv[g]),
      .data_ready(dr[g]),
      .tx_out    (tx[g]),
      .busy      (bsy[g]),
      .done      (dn[g])
    );
  end

  always #5 clk = ~clk;

  function automatic logic fbit(exp_t e, int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return e.b[n-1];
    if (n == 9) return e.p;
    return 1'b1;
  endfunction

  // ---------------- monitor ----------------
  exp_t cur  [N];
  logic act  [N];
  logic abrt [N];
  logic pbusy[N];
  logic pvr  [N];
  int   cyc  [N];
  int   dcnt [N];
  int   dbad [N];
  int   bad  [N];
  int   bad_n[N];
  int   bad_c[N];
  logic bad_g[N];
  int   idle [N];
  int   excl [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      act[i] = 0; abrt[i] = 0; pbusy[i] = 0; pvr[i] = 0; cyc[i] = 0;
      dcnt[i] = 0; dbad[i] = 0; bad[i] = 0; idle[i] = 0; excl[i] = 0;
      bad_n[i] = 0; bad_c[i] = 0; bad_g[i] = 0;
    end
  end

  always @(negedge clk) begin
    int   c, n;
    logic eb;
    for (int i = 0; i < N; i++) begin
      c = (i == 2) ? 1 : 4;
      if (!rst_n) begin
        checks++;
        if (tx[i] !== 1'b1 || bsy[i] !== 1'b0 || dr[i] !== 1'b1 || dn[i] !== 1'b0) begin
          failures++;
          $display("FAIL reset_state dut%0d: tx/busy/ready/done=%b%b%b%b required 1010",
                   i, tx[i], bsy[i], dr[i], dn[i]);
        end
        if (act[i]) abrt[i] = 1;
        idle[i] = 0;
      end else begin
        if (bsy[i] && !pbusy[i]) begin
          if (sb.size() == 0 || sb[0].id != i) begin
            checks++; failures++;
            $display("FAIL unexpected_frame dut%0d: frame started with no matching expectation", i);
          end else begin
            cur[i] = sb.pop_front();
            act[i] = 1; abrt[i] = 0; cyc[i] = 0; dcnt[i] = 0; dbad[i] = 0; bad[i] = 0;
            checks++;
            if (!pvr[i]) begin
              failures++;
              $display("FAIL handshake_latency dut%0d: busy rose without a handshake on the previous edge", i);
            end
            if (cur[i].gap >= 0) begin
              checks++;
              if (idle[i] != cur[i].gap) begin
                failures++;
                $display("FAIL idle_gap dut%0d: got %0d idle cycles required %0d", i, idle[i], cur[i].gap);
              end
            end
          end
        end
        if (act[i] && bsy[i]) begin
          n  = cyc[i] / c;
          eb = fbit(cur[i], n);
          if (tx[i] !== eb) begin
            if (bad[i] == 0) begin
              bad_n[i] = n; bad_c[i] = cyc[i]; bad_g[i] = tx[i];
            end
            bad[i]++;
          end
          if (dn[i] === 1'b1) begin
            dcnt[i]++;
            if (cyc[i] != 11 * c - 1) dbad[i]++;
          end
          cyc[i]++;
        end else if (act[i] && !bsy[i]) begin
          if (abrt[i]) begin
            checks++;
            if (dcnt[i] != 0) begin
              failures++;
              $display("FAIL abort_no_done dut%0d: got %0d done pulses required 0", i, dcnt[i]);
            end
          end else begin
            checks++;
            if (bad[i] != 0) begin
              failures++;
              $display("FAIL frame_bits dut%0d byte=%h: bit %0d at cycle %0d got %b required %b",
                       i, cur[i].b, bad_n[i], bad_c[i], bad_g[i], fbit(cur[i], bad_n[i]));
            end
            checks++;
            if (cyc[i] != 11 * c) begin
              failures++;
              $display("FAIL frame_len dut%0d: got %0d cycles required %0d", i, cyc[i], 11 * c);
            end
            checks++;
            if (dcnt[i] != 1 || dbad[i] != 0) begin
              failures++;
              $display("FAIL done_pulse dut%0d: got %0d pulses (%0d misplaced) required 1 in cycle %0d",
                       i, dcnt[i], dbad[i], 11 * c);
            end
          end
          act[i] = 0; abrt[i] = 0; idle[i] = 0;
        end
        if (bsy[i] !== 1'b1) begin
          idle[i]++;
          if (dr[i] !== 1'b1 || tx[i] !== 1'b1 || dn[i] !== 1'b0 || bsy[i] !== 1'b0) excl[i]++;
        end else if (dr[i] !== 1'b0) begin
          excl[i]++;
        end
      end
      pbusy[i] = rst_n && bsy[i];
      pvr[i]   = rst_n && dv[i] && dr[i];
    end
    if (end_req && !end_done) begin
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL leftover_frames: got %0d frames never transmitted required 0", sb.size());
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (excl[i] != 0) begin
          failures++;
          $display("FAIL ready_busy_idle dut%0d: got %0d bad cycles required 0", i, excl[i]);
        end
      end
      end_done = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int i, input logic [7:0] b, input logic p, input int gap,
                      input logic keep);
    exp_t e;
    logic hs;
    e.id = i; e.b = b; e.p = p; e.gap = gap;
    sb.push_back(e);
    din[i] = b;
    dv[i]  = 1'b1;
    hs = 0;
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk);
      hs = dr[i] && rst_n;
      @(posedge clk);
      #1;
    end
    din[i] = ~b;
    if (!keep) dv[i] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 500; t++) begin
      @(posedge clk);
      if (sb.size() == 0 && bsy == '0) break;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0; rst_n = 0; dv = '0; din = '0;
    checks = 0; failures = 0; end_req = 0; end_done = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    send(0, 8'hA5, 1'b0, -1, 0); drain();
    send(0, 8'h07, 1'b1, -1, 0); drain();
    send(1, 8'h07, 1'b0, -1, 0); drain();
    send(1, 8'h00, 1'b1, -1, 0); drain();
    send(0, 8'h00, 1'b0, -1, 0); drain();
    send(0, 8'hFF, 1'b0, -1, 0); drain();

    send(0, 8'h3C, 1'b0, -1, 1);
    send(0, 8'hC3, 1'b0,  1, 0); drain();

    send(0, 8'h6D, 1'b1, -1, 1);
    repeat (40) begin
      @(posedge clk); #1;
      din[0] = 8'($urandom);
    end
    dv[0] = 1'b0;
    drain();

    send(0, 8'h5A, 1'b0, -1, 0);
    repeat (17) @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    send(0, 8'h13, 1'b1, -1, 0); drain();

    send(2, 8'h81, 1'b0, -1, 1);
    send(2, 8'hE4, 1'b0,  1, 0); drain();

    end_req = 1;
    for (int t = 0; t < 10 && !end_done; t++) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_tx_ctrl.md
# parity_tx_ctrl

Serial frame transmitter that sequences even-parity generation for byte traffic leaving the block. Accepts one byte per valid/ready handshake, computes its parity at capture, and shifts out a framed word: start bit, 8 data bits LSB-first, parity bit, stop bit. Sits between a byte-stream producer and a single-wire serial link; a downstream parity checker consumes the same frame format.

## Interface
- CLKS_PER_BIT, 4: clock cycles each serial bit is held; legal range 1..65535.
- PARITY_ODD, 0: 0 = even parity, so the 9-bit data+parity word has an even number of ones. 1 = odd parity.
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  8  byte to transmit; sampled only on handshake.
- data_valid  input  1  producer has a byte on data_in.
- data_ready  output  1  block can accept a byte; high only in IDLE.
- tx_out  output  1  serial line, registered; idles high.
- busy  output  1  high while a frame is in progress, START through STOP.
- done  output  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The state, bit counter (0..7), cycle counter (0..CLKS_PER_BIT-1), shift register and parity bit are all registered.
- **IDLE:**
  - data_ready=1, tx_out=1, busy=0.
  - On a rising edge with data_valid&&data_ready:
    - latch data_in into the shift register;
    - latch parity = ^data_in (XOR-reduce), inverted if PARITY_ODD=1;
    - go to START and set tx_out<=0.
- **START:** tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with tx_out<=shift[0].
- **DATA:**
  - Each bit is held CLKS_PER_BIT cycles, then the shift register shifts right.
  - After bit 7 completes, go to PARITY with tx_out<=parity.
- **PARITY:** held CLKS_PER_BIT cycles, then go to STOP with tx_out<=1.
- **STOP:**
  - tx_out=1 for CLKS_PER_BIT cycles.
  - done=1 during the last of those cycles.
  - Then return to IDLE.
- The cycle counter resets to 0 on every bit boundary. The bit counter resets on entry to DATA.
- data_in and data_valid are ignored outside IDLE. Changes to data_in after capture never affect the frame in flight.
- data_ready is decoded as (state==IDLE). It is never high in the same cycle as busy.
- Reset (rst_n low, any time including mid-frame):
  - outputs and state go immediately to IDLE, tx_out=1, busy=0, done=0;
  - the frame in flight is abandoned with no done pulse;
  - no byte is accepted while rst_n is low.
- After rst_n deasserts, the first handshake is possible on the first rising edge.

## Timing
- Reset values: tx_out=1, busy=0, done=0, data_ready=1 (state IDLE), counters 0.
- Frame length: 11*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Handshake latency: if the handshake is sampled at edge k, tx_out=0 from edge k through the edge k+CLKS_PER_BIT.
- Bit n of the frame (0=start … 10=stop) occupies cycles k+n*CLKS_PER_BIT+1 to k+(n+1)*CLKS_PER_BIT.
- done is high in cycle k+11*CLKS_PER_BIT. data_ready rises in the following cycle.
- Back-to-back: with data_valid held high, consecutive frames are separated by exactly one IDLE cycle of tx_out=1. The frame period is 11*CLKS_PER_BIT+1 cycles.
- CLKS_PER_BIT=1 is legal: one cycle per bit, 11-cycle frame.
- Counter width is $clog2(CLKS_PER_BIT), with a minimum of 1 bit. No counter wraps beyond its terminal value.

## Test plan
- **0xA5, CLKS_PER_BIT=4, even:**
  - tx_out bit sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles;
  - busy high for 44 cycles;
  - done pulses once in cycle 44.
- **0x07, even:** parity bit = 1. Same byte with PARITY_ODD=1: parity bit = 0. Byte 0x00, even: parity 0. Byte 0xFF, even: parity 0.
- **Back-to-back 0x3C then 0xC3, data_valid held:**
  - exactly one idle-high cycle between frames;
  - second handshake occurs on the cycle data_ready is first high after done;
  - both frames are bit-exact.
- **data_in toggled randomly during a frame:** the transmitted bits match only the captured byte; data_ready stays low until IDLE.
- **Reset mid-frame:** assert rst_n low during DATA bit 3.
  - tx_out=1, busy=0, data_ready=1 asynchronously;
  - no done pulse;
  - the next byte after release transmits a complete, correct frame.
- **CLKS_PER_BIT=1, byte 0x81:** 11-cycle frame 0,1,0,0,0,0,0,0,1,0,1, with done in cycle 11.
